// File: rtl/audio_avg_filter.sv
// Stereo moving-average filter between the codec read and write FIFOs.
// Optional raw-sample bypass input enabled by defining AUDIO_AVG_BYPASS_EN.
module audio_avg_filter #(
  parameter int DATA_W     = 24,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     read_ready,
  input  logic                     write_ready,
`ifdef AUDIO_AVG_BYPASS_EN
  input  logic                     bypass,
`endif
  input  logic signed [DATA_W-1:0] readdata_left,
  input  logic signed [DATA_W-1:0] readdata_right,
  output logic                     read,
  output logic                     write,
  output logic signed [DATA_W-1:0] writedata_left,
  output logic signed [DATA_W-1:0] writedata_right,
  output logic                     busy
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = DATA_W + LOG2_DEPTH;
  localparam int PTR_W = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] ACCUM   = 2'd2;
  localparam logic [1:0] WAIT_WR = 2'd3;

  logic [1:0]               state_q;
  logic                     read_q;
  logic                     write_q;
  logic                     busy_q;
  logic signed [DATA_W-1:0] in_l_q;
  logic signed [DATA_W-1:0] in_r_q;
  logic signed [DATA_W-1:0] wd_l_q;
  logic signed [DATA_W-1:0] wd_r_q;
  logic signed [DATA_W-1:0] hist_l_q [DEPTH];
  logic signed [DATA_W-1:0] hist_r_q [DEPTH];
  logic signed [SUM_W-1:0]  sum_l_q;
  logic signed [SUM_W-1:0]  sum_r_q;
  logic [PTR_W-1:0]         ptr_q;

  logic signed [SUM_W-1:0]  sum_l_d;
  logic signed [SUM_W-1:0]  sum_r_d;
  logic [PTR_W-1:0]         ptr_d;
  logic signed [DATA_W-1:0] wd_l_d;
  logic signed [DATA_W-1:0] wd_r_d;
  logic                     use_raw;

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [DATA_W-1:0] x);
    logic signed [SUM_W-1:0] r;
    r = x;
    return r;
  endfunction

  // Floor division by the window; the sum of DEPTH samples always fits DATA_W after the shift.
  function automatic logic signed [DATA_W-1:0] window_avg(input logic signed [SUM_W-1:0] s);
    return DATA_W'(s >>> LOG2_DEPTH);
  endfunction

`ifdef AUDIO_AVG_BYPASS_EN
  assign use_raw = bypass;
`else
  assign use_raw = 1'b0;
`endif

  always_comb begin
    sum_l_d = sum_l_q + sext(in_l_q) - sext(hist_l_q[ptr_q]);
    sum_r_d = sum_r_q + sext(in_r_q) - sext(hist_r_q[ptr_q]);
    ptr_d   = (LOG2_DEPTH == 0) ? '0 : ptr_q + PTR_W'(1);
    wd_l_d  = use_raw ? in_l_q : window_avg(sum_l_q);
    wd_r_d  = use_raw ? in_r_q : window_avg(sum_r_q);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      in_l_q  <= '0;
      in_r_q  <= '0;
      wd_l_q  <= '0;
      wd_r_q  <= '0;
      sum_l_q <= '0;
      sum_r_q <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_l_q[i] <= '0;
        hist_r_q[i] <= '0;
      end
    end else begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      case (state_q)
        // Pop: latch the pair so read_ready may drop afterwards
        IDLE: begin
          if (read_ready) begin
            in_l_q  <= readdata_left;
            in_r_q  <= readdata_right;
            read_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= CAPTURE;
          end
        end
        // Running sum: add newest sample, retire the one it overwrites
        CAPTURE: begin
          sum_l_q         <= sum_l_d;
          sum_r_q         <= sum_r_d;
          hist_l_q[ptr_q] <= in_l_q;
          hist_r_q[ptr_q] <= in_r_q;
          ptr_q           <= ptr_d;
          state_q         <= ACCUM;
        end
        ACCUM: begin
          wd_l_q  <= wd_l_d;
          wd_r_q  <= wd_r_d;
          state_q <= WAIT_WR;
        end
        // Output held here until the codec has room
        WAIT_WR: begin
          if (write_ready) begin
            write_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign read            = read_q;
  assign write           = write_q;
  assign busy            = busy_q;
  assign writedata_left  = wd_l_q;
  assign writedata_right = wd_r_q;

endmodule

// File: tb/tb_audio_avg_filter.sv
// Randomised self-checking bench for audio_avg_filter against a queue-based moving-average model.
module tb_audio_avg_filter;
  localparam int DW    = 24;
  localparam int L2    = 2;
  localparam int DEPTH = 1 << L2;

  logic                 CLOCK_50;
  logic                 reset;
  logic                 read_ready;
  logic                 write_ready;
  logic signed [DW-1:0] readdata_left;
  logic signed [DW-1:0] readdata_right;
  logic                 read;
  logic                 write;
  logic signed [DW-1:0] writedata_left;
  logic signed [DW-1:0] writedata_right;
  logic                 busy;
`ifdef AUDIO_AVG_BYPASS_EN
  logic                 bypass;
`endif

  audio_avg_filter #(.DATA_W(DW), .LOG2_DEPTH(L2)) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .read_ready      (read_ready),
    .write_ready     (write_ready),
`ifdef AUDIO_AVG_BYPASS_EN
    .bypass          (bypass),
`endif
    .readdata_left   (readdata_left),
    .readdata_right  (readdata_right),
    .read            (read),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .busy            (busy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  bit rnd_wr = 1'b0;
  bit byp_m  = 1'b0;

  int hl[$];
  int hr[$];
  int exp_l[$];
  int exp_r[$];
  int src_l[$];
  int src_r[$];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void model_clear();
    hl.delete();
    hr.delete();
    for (int i = 0; i < DEPTH; i++) begin
      hl.push_back(0);
      hr.push_back(0);
    end
    exp_l.delete();
    exp_r.delete();
  endfunction

  // Window holds the last DEPTH samples; expected output is floor(mean) or the raw sample.
  function automatic void model_push(input int l, input int r);
    hl.push_back(l);
    hr.push_back(r);
    void'(hl.pop_front());
    void'(hr.pop_front());
    exp_l.push_back(byp_m ? l : floor_div(hl.sum(), DEPTH));
    exp_r.push_back(byp_m ? r : floor_div(hr.sum(), DEPTH));
  endfunction

  function automatic int rand_sample();
    logic signed [DW-1:0] t;
    t = DW'($urandom);
    return int'(t);
  endfunction

  // One clock: observe strobes just after the edge and score every write pulse.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    cyc++;
    if (read) rd_cnt++;
    if (write) begin
      wr_cnt++;
      if (exp_l.size() == 0) chk("wr_extra", 1, 0);
      else begin
        chk("wd_left", int'(writedata_left), exp_l.pop_front());
        chk("wd_right", int'(writedata_right), exp_r.pop_front());
      end
    end
    if (rnd_wr) write_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b0;
    read_ready = 1'b0;
    #1;
    chk("rst_read", int'(read), 0);
    chk("rst_write", int'(write), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wd_left", int'(writedata_left), 0);
    chk("rst_wd_right", int'(writedata_right), 0);
    model_clear();
    tick();
    tick();
    @(negedge CLOCK_50);
    reset = 1'b1;
  endtask

  task automatic stream(input bit gap_chk, input bit rnd_gap);
    int n;
    int last;
    bit got;
    n = src_l.size();
    last = 0;
    @(negedge CLOCK_50);
    readdata_left  = DW'(src_l[0]);
    readdata_right = DW'(src_r[0]);
    read_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
        tick();
        if (read) got = 1'b1;
      end
      if (!got) begin
        chk("pop_timeout", 0, 1);
        break;
      end
      model_push(src_l[i], src_r[i]);
      if (gap_chk && i > 0) chk("pop_gap", cyc - last, 4);
      last = cyc;
      readdata_left  = DW'(rand_sample());
      readdata_right = DW'(rand_sample());
      if (i + 1 < n) begin
        if (rnd_gap) begin
          read_ready = 1'b0;
          repeat ($urandom_range(0, 3)) tick();
        end
        readdata_left  = DW'(src_l[i+1]);
        readdata_right = DW'(src_r[i+1]);
        read_ready = 1'b1;
      end else begin
        read_ready = 1'b0;
      end
    end
    src_l.delete();
    src_r.delete();
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && exp_l.size() != 0; c++) tick();
    chk("drain", exp_l.size(), 0);
  endtask

  task automatic add(input int l, input int r);
    src_l.push_back(l);
    src_r.push_back(r);
  endtask

  initial begin
    int rd0;
    int wr0;
    reset = 1'b1;
    read_ready = 1'b0;
    write_ready = 1'b0;
    readdata_left = '0;
    readdata_right = '0;
`ifdef AUDIO_AVG_BYPASS_EN
    bypass = 1'b0;
`endif
    model_clear();

    // Ramp-up then steady state across pointer wrap, both FIFOs always ready
    do_reset();
    write_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      add(64, 64); add(128, 128); add(192, 192); add(256, 256);
    end
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    stream(1'b1, 1'b0);
    drain();
    tick();
    chk("stream_reads", rd_cnt - rd0, 12);
    chk("stream_writes", wr_cnt - wr0, 12);
    chk("idle_busy", int'(busy), 0);

    // Negative inputs round toward minus infinity
    do_reset();
    write_ready = 1'b1;
    add(-4, -1);
    stream(1'b0, 1'b0);
    drain();

    // Output back-pressure: no pops and stable output while pending
    do_reset();
    write_ready = 1'b0;
    add(100, -100);
    stream(1'b0, 1'b0);
    repeat (3) tick();
    @(negedge CLOCK_50);
    readdata_left = 24'sd7;
    readdata_right = 24'sd7;
    read_ready = 1'b1;
    rd0 = rd_cnt;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("hold_write", int'(write), 0);
      chk("hold_read", int'(read), 0);
      chk("hold_busy", int'(busy), 1);
      chk("hold_wd_left", int'(writedata_left), 25);
      chk("hold_wd_right", int'(writedata_right), -25);
    end
    read_ready = 1'b0;
    write_ready = 1'b1;
    wr0 = wr_cnt;
    drain();
    chk("hold_release_busy", int'(busy), 0);
    chk("hold_reads", rd_cnt - rd0, 0);
    tick();
    chk("hold_writes", wr_cnt - wr0, 1);

    // Reset while an output is pending discards it and clears history
    do_reset();
    write_ready = 1'b1;
    add(64, 64); add(128, 128);
    stream(1'b0, 1'b0);
    drain();
    write_ready = 1'b0;
    add(192, 192);
    stream(1'b0, 1'b0);
    repeat (4) tick();
    chk("pend_busy", int'(busy), 1);
    chk("pend_wd_left", int'(writedata_left), 96);
    wr0 = wr_cnt;
    @(negedge CLOCK_50);
    reset = 1'b0;
    #1;
    chk("midrst_write", int'(write), 0);
    chk("midrst_wd_left", int'(writedata_left), 0);
    chk("midrst_wd_right", int'(writedata_right), 0);
    chk("midrst_busy", int'(busy), 0);
    model_clear();
    write_ready = 1'b1;
    repeat (3) tick();
    @(negedge CLOCK_50);
    reset = 1'b1;
    chk("midrst_no_write", wr_cnt - wr0, 0);
    add(64, 64);
    stream(1'b0, 1'b0);
    drain();

    // Random full-range samples with random idle gaps and random write back-pressure
    do_reset();
    for (int i = 0; i < 40; i++) add(rand_sample(), rand_sample());
    rnd_wr = 1'b1;
    stream(1'b0, 1'b1);
    drain();
    rnd_wr = 1'b0;
    write_ready = 1'b1;

`ifdef AUDIO_AVG_BYPASS_EN
    do_reset();
    write_ready = 1'b1;
    bypass = 1'b1;
    byp_m = 1'b1;
    add(64, 64); add(128, 128);
    stream(1'b0, 1'b0);
    drain();
    bypass = 1'b0;
    byp_m = 1'b0;
    add(192, 192);
    stream(1'b0, 1'b0);
    drain();
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
